// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults, forward-select encodings and shadow-entry type for pipe_hazard_sb
package pipe_pkg;
    localparam int NFWD_DEF  = 3;
    localparam int NREG_DEF  = 32;
    localparam int MAXLD_DEF = 2;
    localparam int RNW       = 8;
    localparam int FWD_RF    = 0;
    localparam int FWD_LDRET = NFWD_DEF + 1;
    typedef struct packed {
        logic           v;
        logic           ld;
        logic [RNW-1:0] rn;
    } shadow_t;
    function automatic int fwd_ldret(input int nfwd);
        return nfwd + 1;
    endfunction
endpackage

// File: rtl/pipe_fwd_match.sv
// pipe_fwd_match: youngest-first operand matcher over the shadow pipeline and load-return bus
module pipe_fwd_match import pipe_pkg::*; #(
    parameter int NFWD = NFWD_DEF,
    parameter int AW   = 5,
    parameter int SW   = 3
) (
    input  logic [AW-1:0]      rn,
    input  shadow_t [NFWD-1:0] sh,
    input  logic               mem_done,
    input  logic [AW-1:0]      mem_rn,
    output logic [SW-1:0]      sel,
    output logic               ld_hit
);
    logic hit;
    always_comb begin
        sel    = SW'(FWD_RF);
        hit    = 1'b0;
        ld_hit = 1'b0;
        for (int k = 0; k < NFWD; k++)
            if (!hit && sh[k].v && sh[k].rn == RNW'(rn)) begin
                hit    = 1'b1;
                ld_hit = sh[k].ld;
                sel    = sh[k].ld ? SW'(FWD_RF) : SW'(k + 1);
            end
        if (sel == SW'(FWD_RF) && mem_done && mem_rn == rn)
            sel = SW'(fwd_ldret(NFWD));
        if (rn == '0) begin
            sel    = SW'(FWD_RF);
            ld_hit = 1'b0;
        end
    end
endmodule

// File: rtl/pipe_hazard_sb.sv
// pipe_hazard_sb: issue-hazard scoreboard with forwarding selects; PIPE_HAZARD_PERF_EN enables stall_cnt
module pipe_hazard_sb import pipe_pkg::*; #(
    parameter int NFWD  = NFWD_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int MAXLD = MAXLD_DEF,
    localparam int AW   = $clog2(NREG),
    localparam int SW   = $clog2(NFWD + 2)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wreg,
    input  logic [AW-1:0] id_rd,
    input  logic          id_load,
    output logic          id_ready,
    output logic [SW-1:0] fwda,
    output logic [SW-1:0] fwdb,
    input  logic          mem_done,
    input  logic [AW-1:0] mem_rn,
    output logic          ld_err,
    output logic [31:0]   stall_cnt
);
    localparam int CW = $clog2(MAXLD + 1);
    shadow_t [NFWD-1:0] sh;
    logic [NREG-1:0] pend;
    logic [CW-1:0] cnt;
    logic err, vdone, fire, ld_a, ld_b, haz_a, haz_b, haz_w, haz_s;
    logic [SW-1:0] sel_a, sel_b;
    pipe_fwd_match #(.NFWD(NFWD), .AW(AW), .SW(SW)) u_fwd_a (
        .rn(id_rs), .sh(sh), .mem_done(mem_done), .mem_rn(mem_rn), .sel(sel_a), .ld_hit(ld_a)
    );
    pipe_fwd_match #(.NFWD(NFWD), .AW(AW), .SW(SW)) u_fwd_b (
        .rn(id_rt), .sh(sh), .mem_done(mem_done), .mem_rn(mem_rn), .sel(sel_b), .ld_hit(ld_b)
    );
    // a load returning this very cycle satisfies its consumers and frees its slot
    assign vdone    = mem_done && pend[mem_rn];
    assign haz_a    = id_use_rs && id_rs != '0 && ((pend[id_rs] && !(mem_done && mem_rn == id_rs)) || ld_a);
    assign haz_b    = id_use_rt && id_rt != '0 && ((pend[id_rt] && !(mem_done && mem_rn == id_rt)) || ld_b);
    assign haz_w    = id_wreg && id_rd != '0 && pend[id_rd] && !(mem_done && mem_rn == id_rd);
    assign haz_s    = id_load && cnt == CW'(MAXLD) && !vdone;
    assign id_ready = !clrn || !(haz_a || haz_b || haz_w || haz_s);
    assign fwda     = clrn ? sel_a : '0;
    assign fwdb     = clrn ? sel_b : '0;
    assign fire     = id_valid && id_ready;
    assign ld_err   = err;
    always_ff @(posedge clk) begin
        if (!clrn) begin
            sh   <= '0;
            pend <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            for (int k = NFWD - 1; k > 0; k--) sh[k] <= sh[k-1];
            sh[0] <= shadow_t'{v: fire && id_wreg && id_rd != '0, ld: id_load, rn: RNW'(id_rd)};
            pend  <= (pend & ~(NREG'(vdone) << mem_rn)) | (NREG'(fire && id_load && id_rd != '0) << id_rd);
            cnt   <= cnt + CW'(fire && id_load) - CW'(vdone);
            err   <= err || (mem_done && !pend[mem_rn]);
        end
    end
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stalls;
    always_ff @(posedge clk) begin
        if (!clrn) stalls <= '0;
        else if (id_valid && !id_ready && stalls != '1) stalls <= stalls + 32'd1;
    end
    assign stall_cnt = stalls;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_sb.sv
// tb_pipe_hazard_sb: directed and random checks of pipe_hazard_sb against a behavioural model
module tb_pipe_hazard_sb;
    localparam int NFWD = 3, NREG = 32, MAXLD = 2, AW = 5, SW = 3;
`ifdef PIPE_HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    logic clk = 0, clrn = 0, id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_wreg = 0, id_load = 0, mem_done = 0;
    logic [AW-1:0] id_rs = 0, id_rt = 0, id_rd = 0, mem_rn = 0;
    logic id_ready, ld_err;
    logic [SW-1:0] fwda, fwdb;
    logic [31:0] stall_cnt;
    int total = 0, bad = 0;
    int m_rn[1:NFWD];
    bit m_ld[1:NFWD], m_v[1:NFWD];
    bit pend[NREG];
    int outst = 0;
    bit err = 0, e_ready = 1;
    longint stalls = 0;

    always #5 clk = ~clk;

    pipe_hazard_sb #(.NFWD(NFWD), .NREG(NREG), .MAXLD(MAXLD)) dut (
        .clk(clk), .clrn(clrn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rd(id_rd),
        .id_load(id_load), .id_ready(id_ready), .fwda(fwda), .fwdb(fwdb),
        .mem_done(mem_done), .mem_rn(mem_rn), .ld_err(ld_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int youngest(input int r);
        for (int k = 1; k <= NFWD; k++) if (m_v[k] && m_rn[k] == r) return k;
        return 0;
    endfunction

    function automatic bit src_stall(input int r, input bit used);
        int k;
        if (!used || r == 0) return 0;
        k = youngest(r);
        return (pend[r] && !(mem_done && int'(mem_rn) == r)) || (k != 0 && m_ld[k]);
    endfunction

    // operands whose youngest producer is still an unreturned load are stalled; their select is not judged
    function automatic int sel_of(input int r, output bit ok);
        int k;
        ok = 1;
        if (r == 0) return 0;
        k = youngest(r);
        if (k != 0 && m_ld[k]) begin ok = 0; return 0; end
        if (k != 0) return k;
        if (mem_done && int'(mem_rn) == r) return NFWD + 1;
        return 0;
    endfunction

    task automatic step(input string tag, input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit w, input int rd, input bit ld, input bit md, input int mrn);
        bit ca, cb;
        int fa, fb;
        id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_use_rs = urs; id_use_rt = urt;
        id_wreg = w; id_rd = AW'(rd); id_load = ld; mem_done = md; mem_rn = AW'(mrn);
        #1;
        if (!clrn) begin
            e_ready = 1; fa = 0; fb = 0; ca = 1; cb = 1;
        end else begin
            e_ready = !(src_stall(rs, urs) || src_stall(rt, urt) ||
                        (w && rd != 0 && pend[rd] && !(md && mrn == rd)) ||
                        (ld && outst == MAXLD && !(md && pend[mrn])));
            fa = sel_of(rs, ca);
            fb = sel_of(rt, cb);
        end
        chk({tag, ".ready"}, id_ready, e_ready);
        if (ca) chk({tag, ".fwda"}, fwda, fa);
        if (cb) chk({tag, ".fwdb"}, fwdb, fb);
        chk({tag, ".ld_err"}, ld_err, err);
        chk({tag, ".stall_cnt"}, stall_cnt, PERF ? stalls : 0);
    endtask

    task automatic adv();
        bit fire, vd;
        if (!clrn) begin
            for (int k = 1; k <= NFWD; k++) m_v[k] = 0;
            for (int r = 0; r < NREG; r++) pend[r] = 0;
            outst = 0; err = 0; stalls = 0;
        end else begin
            fire = id_valid && e_ready;
            vd = mem_done && pend[mem_rn];
            if (mem_done && !vd) err = 1;
            if (id_valid && !e_ready && stalls < 64'hFFFF_FFFF) stalls++;
            for (int k = NFWD; k > 1; k--) begin
                m_v[k] = m_v[k-1]; m_rn[k] = m_rn[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[1] = fire && id_wreg && id_rd != 0; m_rn[1] = id_rd; m_ld[1] = id_load;
            if (vd) pend[mem_rn] = 0;
            if (fire && id_load && id_rd != 0) pend[id_rd] = 1;
            outst += int'(fire && id_load) - int'(vd);
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input bit md, input int mrn);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, md, mrn);
        adv();
    endtask

    initial begin
        @(negedge clk);
        step("rst", 1, 3, 4, 1, 1, 0, 0, 0, 0, 0);
        chk("rst.ready_const", id_ready, 1);
        adv();
        clrn = 1;

        step("perf.load", 1, 0, 0, 0, 0, 1, 3, 1, 0, 0); adv();
        repeat (4) begin
            step("perf.stall", 1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
            chk("perf.stall_ready", id_ready, 0);
            adv();
        end
        step("perf.count", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf.count4", stall_cnt, PERF ? 4 : 0);
        adv();
        clrn = 0; idle("perf.rst", 0, 0); clrn = 1;
        step("perf.cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf.count0", stall_cnt, 0);
        adv();

        step("alu.r5", 1, 0, 0, 0, 0, 1, 5, 0, 0, 0); adv();
        for (int k = 1; k <= 4; k++) begin
            step("alu.use", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
            chk("alu.ready", id_ready, 1);
            chk("alu.fwda_stage", fwda, k <= NFWD ? k : 0);
            adv();
        end

        step("ld7.issue", 1, 0, 0, 0, 0, 1, 7, 1, 0, 0); adv();
        repeat (4) begin
            step("ld7.wait", 1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
            chk("ld7.wait_ready", id_ready, 0);
            adv();
        end
        step("ld7.ret", 1, 0, 7, 0, 1, 0, 0, 0, 1, 7);
        chk("ld7.ret_ready", id_ready, 1);
        chk("ld7.ret_fwdb", fwdb, NFWD + 1);
        adv();
        step("ld7.after", 1, 0, 7, 0, 1, 0, 0, 0, 0, 0);
        chk("ld7.after_ready", id_ready, 1);
        chk("ld7.after_fwdb", fwdb, 0);
        adv();

        step("max.l10", 1, 0, 0, 0, 0, 1, 10, 1, 0, 0); adv();
        step("max.l11", 1, 0, 0, 0, 0, 1, 11, 1, 0, 0); adv();
        repeat (3) idle("max.idle", 0, 0);
        step("max.l12", 1, 0, 0, 0, 0, 1, 12, 1, 0, 0);
        chk("max.full_ready", id_ready, 0);
        adv();
        step("max.l12ret", 1, 0, 0, 0, 0, 1, 12, 1, 1, 10);
        chk("max.swap_ready", id_ready, 1);
        adv();
        step("max.l13", 1, 0, 0, 0, 0, 1, 13, 1, 0, 0);
        chk("max.still_full", id_ready, 0);
        adv();
        idle("max.r11", 1, 11);
        idle("max.r12", 1, 12);

        step("r0.write", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); adv();
        step("r0.use", 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk("r0.fwda", fwda, 0);
        chk("r0.fwdb", fwdb, 0);
        chk("r0.ready", id_ready, 1);
        adv();
        idle("err.stray", 1, 9);
        repeat (3) begin
            step("err.hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("err.held", ld_err, 1);
            adv();
        end
        clrn = 0; idle("err.rst", 0, 0); clrn = 1;
        step("err.clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err.cleared", ld_err, 0);
        adv();

        step("mid.ld4", 1, 0, 0, 0, 0, 1, 4, 1, 0, 0); adv();
        clrn = 0;
        step("mid.rstlow", 1, 4, 4, 1, 1, 0, 0, 0, 1, 4);
        chk("mid.rst_ready", id_ready, 1);
        chk("mid.rst_fwda", fwda, 0);
        adv();
        clrn = 1;
        step("mid.forgot", 1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mid.forgot_ready", id_ready, 1);
        adv();

        repeat (600) begin
            bit ld;
            clrn = $urandom_range(0, 99) != 0;
            ld = $urandom_range(0, 3) == 0;
            step("rnd", 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ld | 1'($urandom_range(0, 1)),
                 ld ? $urandom_range(1, 7) : $urandom_range(0, 7), ld,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
